line_tokenizer: RTL and testbench
=================================

LINE_TOKENIZER -- requirements
Module: line_tokenizer

Interface
REQ-001 SHALL have port clk, input, 1, single system clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset sampled on rising edge of clk.
REQ-003 SHALL have port char_in, input, 8, ASCII byte from upstream.
REQ-004 SHALL have port char_valid, input, 1, char_in valid.
REQ-005 SHALL have port char_ready, output, 1, byte accepted on cycle where char_valid && char_ready.
REQ-006 SHALL have port tok_letter, output, 8, token address letter ASCII ('G','X','Y','I','J','F'); 0 for end-of-line-only token.
REQ-007 SHALL have port tok_value, output, 16, signed integer value of token.
REQ-008 SHALL have port tok_eol, output, 1, token terminated by '\n'.
REQ-009 SHALL have port tok_err, output, 1, line contained a syntax/overflow error (with eol token only).
REQ-010 SHALL have port tok_valid / tok_ready, output / input, 1 each, token handshake; transfer when both high.

Function
REQ-011 SHALL classify every byte via one CharDecoder instance (Char_t from Char_PKG); no other character decoding.
REQ-012 SHALL implement states IDLE, LETTER, NUMBER, EMIT, ERROR.
REQ-013 IDLE: letter -> store letter, clear accumulator/sign, go LETTER; space -> stay; '\n' -> EMIT eol-only token (letter 0, value 0, eol 1); digit/'-'/other -> ERROR.
REQ-014 LETTER: '-' (only first char after letter) -> set sign, stay LETTER; digit -> accumulate, go NUMBER; anything else -> ERROR.
REQ-015 NUMBER: digit -> acc = acc*10 + digit; space -> EMIT; '\n' -> EMIT with eol 1; letter -> EMIT and latch letter as pending, next state after EMIT is LETTER.
REQ-016 Magnitude SHALL be limited to 32767; a digit making acc > 32767 -> ERROR; tok_value = sign ? -acc : acc.
REQ-017 tok_valid SHALL assert the cycle after the terminating byte is accepted, hold with stable tok_* until tok_ready, and deassert the cycle after transfer.
REQ-018 char_ready SHALL be 0 in EMIT and 1 in all other states; no byte accepted while a token is pending.
REQ-019 '-' with no digits followed by delimiter SHALL go ERROR.
REQ-020 ERROR: discard all bytes until '\n', then EMIT eol-only token with tok_err 1; tok_err 0 on all other tokens.
REQ-021 Cycles with char_valid low SHALL leave state and accumulator unchanged.

Reset
REQ-022 reset SHALL force state IDLE, accumulator 0, sign 0, pending letter 0.
REQ-023 During/after reset: tok_valid 0, tok_letter 0, tok_value 0, tok_eol 0, tok_err 0, char_ready 0 while reset high, 1 on first cycle after.
REQ-024 reset mid-token or with tok_valid high SHALL drop the pending token without transfer.

Configuration
REQ-025 Macro LINE_TOKENIZER_DOT_EN: when defined, '.' in NUMBER enters fraction sub-mode; following digits consumed and discarded (truncation), delimiters handled as NUMBER; second '.' -> ERROR.
REQ-026 Without LINE_TOKENIZER_DOT_EN, '.' in any state except ERROR -> ERROR.

Structure
REQ-027 Char_t stays in Char_PKG; new Tokenizer_PKG SHALL hold state enum, TOK_VALUE_BITS = 16, TOK_MAX_MAG = 32767, EOL letter code 0.
REQ-028 CharDecoder SHALL be the sole sub-module; FSM, accumulator, output register in line_tokenizer.

Verification
REQ-029 Bytes "G1 X-25\n", tok_ready 1 -> tokens (G,1,eol0), (X,-25,eol1), err 0 on all.
REQ-030 "X12Y34\n" -> (X,12,eol0), (Y,34,eol1); Y consumed as terminator of X.
REQ-031 "X40000\n" -> single eol-only token letter 0, value 0, err 1; no X token.
REQ-032 "G1 " with tok_ready held 0 for 5 cycles -> tok_valid high and stable 5 cycles, char_ready 0 throughout; one transfer when tok_ready rises.
REQ-033 "X1.5\n": with LINE_TOKENIZER_DOT_EN -> (X,1,eol1,err0); without -> eol-only token, err 1.
REQ-034 reset asserted after "Y-3" accepted, then "\n" -> single eol-only token, letter 0, err 0.

Source files
------------

// File: rtl/Char_PKG.sv
// Character classes shared by the byte decoder and the tokenizer.
// Only the upper-case address letters G X Y I J F count as letters.
package Char_PKG;

  typedef enum logic [2:0] {
    CH_OTHER,
    CH_LETTER,
    CH_DIGIT,
    CH_MINUS,
    CH_SPACE,
    CH_EOL,
    CH_DOT
  } char_cls_e;

  typedef struct packed {
    char_cls_e   cls;
    logic [3:0]  digit;
    logic [7:0]  code;
  } Char_t;

endpackage

// File: rtl/Tokenizer_PKG.sv
// Tokenizer state encoding, value limits and accumulator helper.
// The end-of-line-only token carries letter code EOL_LETTER.
package Tokenizer_PKG;

  localparam int TOK_VALUE_BITS = 16;
  localparam int TOK_MAX_MAG    = 32767;
  localparam int ACC_NX_BITS    = 20;

  localparam logic [7:0] EOL_LETTER = 8'd0;

  typedef enum logic [2:0] {
    IDLE,
    LETTER,
    NUMBER,
    EMIT,
    ERROR
  } tok_state_e;

  function automatic logic [ACC_NX_BITS-1:0] acc_mac10(
    input logic [TOK_VALUE_BITS-1:0] acc,
    input logic [3:0]                dig
  );
    logic [ACC_NX_BITS-1:0] wide;
    wide = {{(ACC_NX_BITS-TOK_VALUE_BITS){1'b0}}, acc};
    return (wide * ACC_NX_BITS'(10))
         + {{(ACC_NX_BITS-4){1'b0}}, dig};
  endfunction

endpackage

// File: rtl/CharDecoder.sv
// Classifies one ASCII byte into a Char_t record.
// This is the only place where byte values are interpreted.
module CharDecoder
  import Char_PKG::*;
(
  input  logic [7:0] char_in,
  output Char_t      ch
);

  // one-hot style class decode of the incoming byte
  always_comb begin
    ch.code  = char_in;
    ch.digit = char_in[3:0];
    ch.cls   = CH_OTHER;
    unique case (1'b1)
      (char_in >= "0" && char_in <= "9"):
        ch.cls = CH_DIGIT;
      (char_in == "G" || char_in == "X" ||
       char_in == "Y" || char_in == "I" ||
       char_in == "J" || char_in == "F"):
        ch.cls = CH_LETTER;
      (char_in == "-"):
        ch.cls = CH_MINUS;
      (char_in == " "):
        ch.cls = CH_SPACE;
      (char_in == 8'h0a):
        ch.cls = CH_EOL;
      (char_in == "."):
        ch.cls = CH_DOT;
      default:
        ch.cls = CH_OTHER;
    endcase
  end

endmodule

// File: rtl/line_tokenizer.sv
// G-code style line tokenizer: letter + signed integer tokens.
// Define LINE_TOKENIZER_DOT_EN to accept and truncate fractions.
module line_tokenizer
  import Char_PKG::*;
  import Tokenizer_PKG::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  char_in,
  input  logic        char_valid,
  output logic        char_ready,
  output logic [7:0]  tok_letter,
  output logic [15:0] tok_value,
  output logic        tok_eol,
  output logic        tok_err,
  output logic        tok_valid,
  input  logic        tok_ready
);

  localparam int VB = TOK_VALUE_BITS;

  Char_t ch;

  CharDecoder u_dec (
    .char_in (char_in),
    .ch      (ch)
  );

  tok_state_e state_q, state_d;
  logic [7:0]    let_q, let_d;
  logic [7:0]    pend_q, pend_d;
  logic [VB-1:0] acc_q, acc_d;
  logic          neg_q, neg_d;
  logic          frac_q, frac_d;
  logic [7:0]    tl_q, tl_d;
  logic [VB-1:0] tv_q, tv_d;
  logic          te_q, te_d;
  logic          tr_q, tr_d;

  logic                   fire;
  logic [ACC_NX_BITS-1:0] acc_nx;
  logic [VB-1:0]          val_s;
  logic                   take_dig;

  assign char_ready = !reset && (state_q != EMIT);
  assign fire       = char_valid && char_ready;
  assign acc_nx     = acc_mac10(acc_q, ch.digit);
  assign val_s      = neg_q ? (~acc_q + VB'(1)) : acc_q;
  assign take_dig   = !frac_q;

  assign tok_valid  = !reset && (state_q == EMIT);
  assign tok_letter = tl_q;
  assign tok_value  = tv_q;
  assign tok_eol    = te_q;
  assign tok_err    = tr_q;

  logic          em;
  logic [7:0]    em_l;
  logic [VB-1:0] em_v;
  logic          em_e;
  logic          em_r;

  // next-state, accumulator and token capture
  always_comb begin
    state_d = state_q;
    let_d   = let_q;
    pend_d  = pend_q;
    acc_d   = acc_q;
    neg_d   = neg_q;
    frac_d  = frac_q;
    tl_d    = tl_q;
    tv_d    = tv_q;
    te_d    = te_q;
    tr_d    = tr_q;
    em      = 1'b0;
    em_l    = EOL_LETTER;
    em_v    = '0;
    em_e    = 1'b1;
    em_r    = 1'b0;
    unique case (state_q)
      IDLE: if (fire) begin
        case (ch.cls)
          CH_LETTER: begin
            let_d   = ch.code;
            acc_d   = '0;
            neg_d   = 1'b0;
            frac_d  = 1'b0;
            state_d = LETTER;
          end
          CH_SPACE: ;
          CH_EOL:   em = 1'b1;
          default:  state_d = ERROR;
        endcase
      end
      LETTER: if (fire) begin
        case (ch.cls)
          CH_MINUS: begin
            if (neg_q) state_d = ERROR;
            else       neg_d   = 1'b1;
          end
          CH_DIGIT: begin
            acc_d   = {{(VB-4){1'b0}}, ch.digit};
            state_d = NUMBER;
          end
          // the newline is already consumed, so flag it now
          CH_EOL: begin
            em   = 1'b1;
            em_r = 1'b1;
          end
          default: state_d = ERROR;
        endcase
      end
      NUMBER: if (fire) begin
        case (ch.cls)
          CH_DIGIT: begin
            if (take_dig) begin
              if (acc_nx > ACC_NX_BITS'(TOK_MAX_MAG))
                state_d = ERROR;
              else
                acc_d = acc_nx[VB-1:0];
            end
          end
          CH_SPACE: begin
            em   = 1'b1;
            em_l = let_q;
            em_v = val_s;
            em_e = 1'b0;
          end
          CH_EOL: begin
            em   = 1'b1;
            em_l = let_q;
            em_v = val_s;
          end
          CH_LETTER: begin
            em     = 1'b1;
            em_l   = let_q;
            em_v   = val_s;
            em_e   = 1'b0;
            pend_d = ch.code;
          end
          CH_DOT: begin
`ifdef LINE_TOKENIZER_DOT_EN
            if (frac_q) state_d = ERROR;
            else        frac_d  = 1'b1;
`else
            state_d = ERROR;
`endif
          end
          default: state_d = ERROR;
        endcase
      end
      EMIT: if (tok_ready) begin
        state_d = (pend_q != EOL_LETTER) ? LETTER : IDLE;
        let_d   = pend_q;
        pend_d  = EOL_LETTER;
        acc_d   = '0;
        neg_d   = 1'b0;
        frac_d  = 1'b0;
      end
      ERROR: if (fire && ch.cls == CH_EOL) begin
        em   = 1'b1;
        em_r = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (em) begin
      state_d = EMIT;
      tl_d    = em_l;
      tv_d    = em_v;
      te_d    = em_e;
      tr_d    = em_r;
    end
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      let_q   <= EOL_LETTER;
      pend_q  <= EOL_LETTER;
      acc_q   <= '0;
      neg_q   <= 1'b0;
      frac_q  <= 1'b0;
      tl_q    <= EOL_LETTER;
      tv_q    <= '0;
      te_q    <= 1'b0;
      tr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      let_q   <= let_d;
      pend_q  <= pend_d;
      acc_q   <= acc_d;
      neg_q   <= neg_d;
      frac_q  <= frac_d;
      tl_q    <= tl_d;
      tv_q    <= tv_d;
      te_q    <= te_d;
      tr_q    <= tr_d;
    end
  end

endmodule

// File: tb/tb_line_tokenizer.sv
// Self-checking bench for line_tokenizer: vectors, corners, random.
// Honours LINE_TOKENIZER_DOT_EN for the expected fraction behaviour.
module tb_line_tokenizer;

  typedef struct packed {
    logic [7:0]  l;
    logic [15:0] v;
    logic        e;
    logic        r;
  } tok_t;

  typedef struct packed {
    logic [63:0] s;
    logic [1:0]  n;
    tok_t        t0;
    tok_t        t1;
  } vec_t;

`ifdef LINE_TOKENIZER_DOT_EN
  localparam bit DOT = 1'b1;
`else
  localparam bit DOT = 1'b0;
`endif

  localparam int LIM = 40000;

  logic        clk;
  logic        reset;
  logic [7:0]  char_in;
  logic        char_valid;
  logic        char_ready;
  logic [7:0]  tok_letter;
  logic [15:0] tok_value;
  logic        tok_eol;
  logic        tok_err;
  logic        tok_valid;
  logic        tok_ready;

  int checks = 0;
  int errors = 0;

  logic [7:0] in_q[$];
  tok_t       exp_q[$];

  line_tokenizer dut (
    .clk        (clk),
    .reset      (reset),
    .char_in    (char_in),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .tok_letter (tok_letter),
    .tok_value  (tok_value),
    .tok_eol    (tok_eol),
    .tok_err    (tok_err),
    .tok_valid  (tok_valid),
    .tok_ready  (tok_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic tok_t tk(logic [7:0] l, int v,
                              bit e, bit r);
    tok_t t;
    t.l = l;
    t.v = v[15:0];
    t.e = e;
    t.r = r;
    return t;
  endfunction

  function automatic vec_t mkv(logic [63:0] s, int n,
                               tok_t t0, tok_t t1);
    vec_t x;
    x.s  = s;
    x.n  = n[1:0];
    x.t0 = t0;
    x.t1 = t1;
    return x;
  endfunction

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic bit is_let(logic [7:0] c);
    return c == "G" || c == "X" || c == "Y" ||
           c == "I" || c == "J" || c == "F";
  endfunction

  function automatic bit is_dig(logic [7:0] c);
    return c >= "0" && c <= "9";
  endfunction

  // reference parser: one complete line -> expected tokens
  function automatic void model_line(input logic [7:0] ln[$]);
    int i = 0;
    int v;
    bit neg;
    bit hl = 0;
    logic [7:0] L = 0;
    while (i < ln.size()) begin
      if (!hl) begin
        while (ln[i] == " ") i++;
        if (ln[i] == 8'h0a) begin
          exp_q.push_back(tk(0, 0, 1, 0));
          return;
        end
        if (!is_let(ln[i])) break;
        L = ln[i];
        i++;
      end
      hl = 0;
      neg = (ln[i] == "-");
      if (neg) i++;
      if (!is_dig(ln[i])) break;
      v = 0;
      while (is_dig(ln[i]) && v <= 32767) begin
        v = v * 10 + int'(ln[i] - "0");
        i++;
      end
      if (v > 32767) break;
      if (DOT && ln[i] == ".") begin
        i++;
        while (is_dig(ln[i])) i++;
      end
      if (neg) v = -v;
      if (ln[i] == 8'h0a) begin
        exp_q.push_back(tk(L, v, 1, 0));
        return;
      end else if (ln[i] == " ") begin
        exp_q.push_back(tk(L, v, 0, 0));
        i++;
      end else if (is_let(ln[i])) begin
        exp_q.push_back(tk(L, v, 0, 0));
        L = ln[i];
        i++;
        hl = 1;
      end else begin
        break;
      end
    end
    exp_q.push_back(tk(0, 0, 1, 1));
  endfunction

  function automatic void gen_line();
    logic [7:0] ln[$];
    string lets = "GXYIJF";
    string junk = " -.5Az!";
    int k = $urandom_range(4, 1);
    int nd;
    int r;
    for (int j = 0; j < k; j++) begin
      if ($urandom_range(99) < 75) begin
        ln.push_back(lets[$urandom_range(5)]);
        if ($urandom_range(99) < 20) ln.push_back("-");
        nd = ($urandom_range(99) < 5) ? 0 : $urandom_range(5, 1);
        for (int d = 0; d < nd; d++)
          ln.push_back(8'(48 + $urandom_range(9)));
        if ($urandom_range(99) < 15) begin
          ln.push_back(".");
          nd = $urandom_range(2);
          for (int d = 0; d < nd; d++)
            ln.push_back(8'(48 + $urandom_range(9)));
        end
        r = $urandom_range(99);
        if (r < 50) ln.push_back(" ");
        else if (r < 60) begin
          ln.push_back(" ");
          ln.push_back(" ");
        end
      end else begin
        ln.push_back(junk[$urandom_range(6)]);
      end
    end
    ln.push_back(8'h0a);
    model_line(ln);
    foreach (ln[j]) in_q.push_back(ln[j]);
  endfunction

  task automatic take_tok();
    tok_t got;
    tok_t w;
    got = {tok_letter, tok_value, tok_eol, tok_err};
    chk("ready_low_in_emit", {31'd0, char_ready}, 32'd0);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_token: got %h want none", got);
    end else begin
      w = exp_q.pop_front();
      chk("token", {6'd0, got}, {6'd0, w});
    end
  endtask

  // drive in_q with random gaps/backpressure, check against exp_q
  task automatic run(int rdy_pct, int val_pct);
    int cyc = 0;
    int extra = 0;
    while ((in_q.size() > 0 || exp_q.size() > 0) && cyc < LIM) begin
      @(negedge clk);
      cyc++;
      tok_ready = ($urandom_range(99) < rdy_pct);
      if (tok_valid && tok_ready) take_tok();
      if (in_q.size() > 0 && $urandom_range(99) < val_pct) begin
        char_valid = 1'b1;
        char_in    = in_q[0];
        if (char_ready) void'(in_q.pop_front());
      end else begin
        char_valid = 1'b0;
        char_in    = 8'($urandom);
      end
    end
    chk("run_timeout", {31'd0, cyc >= LIM}, 32'd0);
    repeat (6) begin
      @(negedge clk);
      char_valid = 1'b0;
      tok_ready  = 1'b1;
      if (tok_valid) extra++;
    end
    chk("no_extra_token", extra, 0);
    in_q.delete();
    exp_q.delete();
    tok_ready = 1'b0;
  endtask

  task automatic send_byte(logic [7:0] b);
    int n = 0;
    char_in    = b;
    char_valid = 1'b1;
    while (!char_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    char_valid = 1'b0;
    if (n >= 50) chk("send_timeout", n, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  vec_t vt[16];

  initial begin
    logic [7:0] b;
    tok_t       t;
    reset      = 1'b1;
    char_valid = 1'b0;
    char_in    = 8'd0;
    tok_ready  = 1'b0;

    vt[0]  = mkv("G1 X-25\n", 2, tk("G", 1, 0, 0),
                 tk("X", -25, 1, 0));
    vt[1]  = mkv("X12Y34\n", 2, tk("X", 12, 0, 0),
                 tk("Y", 34, 1, 0));
    vt[2]  = mkv("X40000\n", 1, tk(0, 0, 1, 1), '0);
    vt[3]  = mkv("X1.5\n", 1,
                 DOT ? tk("X", 1, 1, 0) : tk(0, 0, 1, 1), '0);
    vt[4]  = mkv("\n", 1, tk(0, 0, 1, 0), '0);
    vt[5]  = mkv("X32767\n", 1, tk("X", 32767, 1, 0), '0);
    vt[6]  = mkv("Y-32767\n", 1, tk("Y", -32767, 1, 0), '0);
    vt[7]  = mkv("X32768\n", 1, tk(0, 0, 1, 1), '0);
    vt[8]  = mkv("G- X1\n", 1, tk(0, 0, 1, 1), '0);
    vt[9]  = mkv("G1 \n", 2, tk("G", 1, 0, 0),
                 tk(0, 0, 1, 0));
    vt[10] = mkv("X1..2\n", 1, tk(0, 0, 1, 1), '0);
    vt[11] = mkv("7 G1\n", 1, tk(0, 0, 1, 1), '0);
    vt[12] = mkv("J0 F9\n", 2, tk("J", 0, 0, 0),
                 tk("F", 9, 1, 0));
    vt[13] = mkv("G--1\n", 1, tk(0, 0, 1, 1), '0);
    vt[14] = mkv("I5.\n", 1,
                 DOT ? tk("I", 5, 1, 0) : tk(0, 0, 1, 1), '0);
    vt[15] = mkv("X\n", 1, tk(0, 0, 1, 1), '0);

    repeat (2) @(negedge clk);
    chk("rst_char_ready", {31'd0, char_ready}, 32'd0);
    chk("rst_tok_valid", {31'd0, tok_valid}, 32'd0);
    chk("rst_tok_fields",
        {6'd0, tok_letter, tok_value, tok_eol, tok_err}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, char_ready}, 32'd1);

    for (int k = 0; k < 16; k++) begin
      for (int c = 7; c >= 0; c--) begin
        b = vt[k].s[8*c+:8];
        if (b != 8'd0) in_q.push_back(b);
      end
      exp_q.push_back(vt[k].t0);
      if (vt[k].n == 2'd2) exp_q.push_back(vt[k].t1);
      run((k % 2 == 0) ? 100 : 50, (k % 3 == 0) ? 100 : 60);
    end

    tok_ready = 1'b0;
    send_byte("G");
    send_byte("1");
    send_byte(" ");
    t = tk("G", 1, 0, 0);
    for (int k = 0; k < 5; k++) begin
      chk("stall_valid", {31'd0, tok_valid}, 32'd1);
      chk("stall_fields",
          {6'd0, tok_letter, tok_value, tok_eol, tok_err},
          {6'd0, t});
      chk("stall_ready", {31'd0, char_ready}, 32'd0);
      @(negedge clk);
    end
    tok_ready = 1'b1;
    @(negedge clk);
    tok_ready = 1'b0;
    chk("one_transfer", {31'd0, tok_valid}, 32'd0);
    chk("ready_after_xfer", {31'd0, char_ready}, 32'd1);

    send_byte("Y");
    send_byte("-");
    send_byte("3");
    reset = 1'b1;
    @(negedge clk);
    chk("midtok_rst_ready", {31'd0, char_ready}, 32'd0);
    reset = 1'b0;
    in_q.push_back(8'h0a);
    exp_q.push_back(tk(0, 0, 1, 0));
    run(100, 100);

    send_byte("X");
    send_byte("7");
    send_byte(" ");
    chk("pending_before_rst", {31'd0, tok_valid}, 32'd1);
    do_reset();
    chk("drop_on_rst", {31'd0, tok_valid}, 32'd0);
    in_q.push_back(8'h0a);
    exp_q.push_back(tk(0, 0, 1, 0));
    run(100, 100);

    for (int k = 0; k < 300; k++) gen_line();
    run(70, 75);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
